// File: rtl/fft_bf_stage_if.sv
// Handshake and datapath bundle for one radix-2 butterfly stage.
// The bench or upstream logic holds the master side; the stage holds the slave side.
interface fft_bf_stage_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a_re;
  logic signed [W-1:0] a_im;
  logic signed [W-1:0] b_re;
  logic signed [W-1:0] b_im;
  logic [1:0]          tw_sel;
  logic                scale_en;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] y0_re;
  logic signed [W-1:0] y0_im;
  logic signed [W-1:0] y1_re;
  logic signed [W-1:0] y1_im;
  logic                sat_flag;
  logic                sat_clr;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, tw_sel, scale_en, out_ready, sat_clr,
    input  in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, sat_flag
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, tw_sel, scale_en, out_ready, sat_clr,
    output in_ready, out_valid, y0_re, y0_im, y1_re, y1_im, sat_flag
  );
endinterface

// File: rtl/fft_bf_stage.sv
// Radix-2 DIT butterfly: y0 = a + b*w, y1 = a - b*w with twiddle 1, -j, W8^1 or W8^3.
// Stage 1 rotates b, stage 2 adds/subtracts, optionally halves, and saturates.
module fft_bf_stage #(
  parameter int W      = 16,
  parameter int COEF_W = 16
) (
  input logic           clk,
  input logic           reset,
  fft_bf_stage_if.slave bus
);
  localparam int PW = W + COEF_W + 3;
  localparam longint COEF_L = (64'sd707106781 * (64'sd1 <<< (COEF_W - 1)) + 64'sd500000000)
                              / 64'sd1000000000;
  localparam logic signed [PW-1:0] COEF_P = PW'(COEF_L);
  localparam logic signed [PW-1:0] RND_P  = PW'(64'sd1 <<< (COEF_W - 2));
  localparam logic signed [W+1:0]  MAX_V  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0]  MIN_V  = {3'b111, {(W-1){1'b0}}};

  function automatic logic signed [W+1:0] sx_w(input logic signed [W-1:0] x);
    return $signed({{2{x[W-1]}}, x});
  endfunction

  function automatic logic signed [W+1:0] sx_w1(input logic signed [W:0] x);
    return $signed({x[W], x});
  endfunction

  // Multiply by C/2^(COEF_W-1) with round-half-up.
  function automatic logic signed [W:0] rot_round(input logic signed [W+1:0] s);
    logic signed [PW-1:0] p;
    p = $signed({{(PW-W-2){s[W+1]}}, s}) * COEF_P;
    p = (p + RND_P) >>> (COEF_W - 1);
    return p[W:0];
  endfunction

  function automatic logic signed [W+1:0] halve(input logic signed [W+1:0] x, input logic en);
    if (en) begin
      return x >>> 1;
    end else begin
      return x;
    end
  endfunction

  function automatic logic sat_hit(input logic signed [W+1:0] x);
    return (x > MAX_V) || (x < MIN_V);
  endfunction

  function automatic logic signed [W-1:0] sat_val(input logic signed [W+1:0] x);
    if (x > MAX_V) begin
      return MAX_V[W-1:0];
    end else if (x < MIN_V) begin
      return MIN_V[W-1:0];
    end else begin
      return x[W-1:0];
    end
  endfunction

  logic                adv_s;
  logic signed [W+1:0] br_s, bi_s, t_re_s, t_im_s;
  logic                rnd_s;
  logic signed [W:0]   rot_re_s, rot_im_s;
  logic                v1_r, scale1_r;
  logic signed [W-1:0] a_re1_r, a_im1_r;
  logic signed [W:0]   rb_re1_r, rb_im1_r;
  logic signed [W+1:0] s0re_s, s0im_s, s1re_s, s1im_s;
  logic                clamp_s;
  logic                v2_r, sat_r;
  logic signed [W-1:0] y0_re_r, y0_im_r, y1_re_r, y1_im_r;

  assign adv_s        = !(v2_r && !bus.out_ready);
  assign bus.in_ready = adv_s;

  // Twiddle rotation of b; sums carry one extra bit so -b_re-b_im cannot wrap.
  always_comb begin
    br_s   = sx_w(bus.b_re);
    bi_s   = sx_w(bus.b_im);
    t_re_s = br_s;
    t_im_s = bi_s;
    rnd_s  = 1'b0;
    case (bus.tw_sel)
      2'd0: begin t_re_s = br_s;         t_im_s = bi_s;         rnd_s = 1'b0; end
      2'd1: begin t_re_s = bi_s;         t_im_s = -br_s;        rnd_s = 1'b0; end
      2'd2: begin t_re_s = br_s + bi_s;  t_im_s = bi_s - br_s;  rnd_s = 1'b1; end
      2'd3: begin t_re_s = bi_s - br_s;  t_im_s = -br_s - bi_s; rnd_s = 1'b1; end
      default: begin
        t_re_s = {(W+2){1'b0}};
        t_im_s = {(W+2){1'b0}};
        rnd_s  = 1'b0;
      end
    endcase
    if (rnd_s) begin
      rot_re_s = rot_round(t_re_s);
      rot_im_s = rot_round(t_im_s);
    end else begin
      rot_re_s = t_re_s[W:0];
      rot_im_s = t_im_s[W:0];
    end
  end

  // Stage-1 register: operand a, rotated b and the per-beat scale mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r     <= 1'b0;
      scale1_r <= 1'b0;
      a_re1_r  <= {W{1'b0}};
      a_im1_r  <= {W{1'b0}};
      rb_re1_r <= {(W+1){1'b0}};
      rb_im1_r <= {(W+1){1'b0}};
    end else if (adv_s) begin
      v1_r     <= bus.in_valid;
      scale1_r <= bus.scale_en;
      a_re1_r  <= bus.a_re;
      a_im1_r  <= bus.a_im;
      rb_re1_r <= rot_re_s;
      rb_im1_r <= rot_im_s;
    end
  end

  // Butterfly sums/differences with optional halving, ahead of saturation.
  always_comb begin
    s0re_s  = halve(sx_w(a_re1_r) + sx_w1(rb_re1_r), scale1_r);
    s0im_s  = halve(sx_w(a_im1_r) + sx_w1(rb_im1_r), scale1_r);
    s1re_s  = halve(sx_w(a_re1_r) - sx_w1(rb_re1_r), scale1_r);
    s1im_s  = halve(sx_w(a_im1_r) - sx_w1(rb_im1_r), scale1_r);
    clamp_s = sat_hit(s0re_s) | sat_hit(s0im_s) | sat_hit(s1re_s) | sat_hit(s1im_s);
  end

  // Stage-2 register drives the outputs directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_r    <= 1'b0;
      y0_re_r <= {W{1'b0}};
      y0_im_r <= {W{1'b0}};
      y1_re_r <= {W{1'b0}};
      y1_im_r <= {W{1'b0}};
    end else if (adv_s) begin
      v2_r    <= v1_r;
      y0_re_r <= sat_val(s0re_s);
      y0_im_r <= sat_val(s0im_s);
      y1_re_r <= sat_val(s1re_s);
      y1_im_r <= sat_val(s1im_s);
    end
  end

  // Sticky saturation flag; a new clamp beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_r <= 1'b0;
    end else if (adv_s && v1_r && clamp_s) begin
      sat_r <= 1'b1;
    end else if (bus.sat_clr) begin
      sat_r <= 1'b0;
    end
  end

  assign bus.out_valid = v2_r;
  assign bus.y0_re     = y0_re_r;
  assign bus.y0_im     = y0_im_r;
  assign bus.y1_re     = y1_re_r;
  assign bus.y1_im     = y1_im_r;
  assign bus.sat_flag  = sat_r;
endmodule

// File: tb/tb_fft_bf_stage.sv
// Scoreboard bench for fft_bf_stage: driver pushes expected results, monitor pops on handshake.
module tb_fft_bf_stage;
  localparam int W = 16;

  typedef struct {
    int y0re;
    int y0im;
    int y1re;
    int y1im;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic bp_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  fft_bf_stage_if #(.W(W)) bus();

  fft_bf_stage #(.W(W), .COEF_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream ready: random while backpressure is enabled, else always ready.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: outputs must match the head of the scoreboard whenever valid, also while stalled.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("y0_re", int'(bus.y0_re), sb[0].y0re);
        chk("y0_im", int'(bus.y0_im), sb[0].y0im);
        chk("y1_re", int'(bus.y1_re), sb[0].y1re);
        chk("y1_im", int'(bus.y1_im), sb[0].y1im);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input int are, input int aim, input int bre, input int bim,
                      input int tw, input int sc,
                      input int e0r, input int e0i, input int e1r, input int e1i);
    bit   acc;
    exp_t e;
    e.y0re = e0r; e.y0im = e0i; e.y1re = e1r; e.y1im = e1i;
    bus.a_re     = 16'(are);
    bus.a_im     = 16'(aim);
    bus.b_re     = 16'(bre);
    bus.b_im     = 16'(bim);
    bus.tw_sel   = 2'(tw);
    bus.scale_en = 1'(sc);
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic check_sat(input string nm, input int exp);
    @(negedge clk);
    chk(nm, int'(bus.sat_flag), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_re     = 16'sd0;
    bus.a_im     = 16'sd0;
    bus.b_re     = 16'sd0;
    bus.b_im     = 16'sd0;
    bus.tw_sel   = 2'd0;
    bus.scale_en = 1'b0;
    bus.sat_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_sat_flag", int'(bus.sat_flag), 0);
    chk("rst_y0_re", int'(bus.y0_re), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    reset = 1'b0;

    // Directed twiddle / rounding / floor vectors, back to back.
    send(100, -50, 20, 30, 0, 0,   120, -20, 80, -80);
    send(0, 0, 3, 5, 1, 0,         5, -3, -5, 3);
    send(1000, 0, 10000, 0, 2, 0,  8071, -7071, -6071, 7071);
    send(0, 0, 10000, 0, 3, 0,     -7071, -7071, 7071, 7071);
    send(0, 0, 1, 0, 2, 0,         1, -1, -1, 1);
    send(-3, 0, 0, 0, 0, 1,        -2, 0, -2, 0);
    drain();
    check_sat("sat_after_clean", 0);

    send(30000, 0, 10000, 0, 0, 0, 32767, 0, 20000, 0);
    drain();
    check_sat("sat_after_clamp", 1);
    bus.sat_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.sat_clr = 1'b0;
    check_sat("sat_after_clr", 0);
    send(30000, 0, 10000, 0, 0, 1, 20000, 0, 10000, 0);
    drain();
    check_sat("sat_scaled_no_clamp", 0);
    send(-32768, 0, -32768, 0, 1, 0, -32768, 32767, -32768, -32768);
    drain();
    check_sat("sat_min_neg", 1);

    // Stream under random backpressure; monitor checks order and hold-stability.
    bp_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(100 * i, -i, i, 2 * i, 0, 0, 101 * i, i, 99 * i, -3 * i);
    end
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset with two beats in flight.
    bus.a_re = 16'sd100; bus.a_im = -16'sd50; bus.b_re = 16'sd20; bus.b_im = 16'sd30;
    bus.tw_sel = 2'd0; bus.scale_en = 1'b0; bus.in_valid = 1'b1;
    sb.push_back('{120, -20, 80, -80});
    @(posedge clk);
    #1;
    bus.a_re = 16'sd0; bus.a_im = 16'sd0; bus.b_re = 16'sd3; bus.b_im = 16'sd5;
    bus.tw_sel = 2'd1;
    sb.push_back('{5, -3, -5, 3});
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_y0_re", int'(bus.y0_re), 0);
    chk("rst_mid_y1_im", int'(bus.y1_im), 0);
    chk("rst_mid_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", int'(bus.out_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
